fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with in-order response buffer and redirect handling
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);
    localparam int            CW    = $clog2(DEPTH + 1);
    localparam int            PW    = $clog2(DEPTH);
    localparam logic [CW:0]   LIMIT = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_disc;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [31:0]   r_buf_pc    [DEPTH];
    logic [31:0]   r_buf_instr [DEPTH];

    logic          w_redirect;
    logic          w_rsp;
    logic          w_hs;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_out_next;
    logic [CW-1:0] w_disc_next;
    logic [31:0]   w_redirect_pc;
    logic [1:0]    w_unused_pc_lsbs;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign w_redirect_pc    = {redirect_pc[31:2], 2'b00};
    assign w_unused_pc_lsbs = redirect_pc[1:0];

    // Responses with nothing outstanding are protocol errors and are dropped here.
    assign w_redirect = redirect_valid && (r_state != S_IDLE);
    assign w_rsp      = imem_rsp_valid && (r_out != '0);
    assign w_hs       = imem_req_valid && imem_req_ready;
    assign w_push     = w_rsp && (r_disc == '0) && !w_redirect;
    assign w_pop      = instr_valid && instr_ready && !w_redirect;

    assign imem_req_valid = (r_state == S_FETCH) && !redirect_valid &&
                            (({1'b0, r_out} + {1'b0, r_cnt}) < LIMIT);
    assign imem_addr      = r_fetch_pc;

    assign instr_valid = (r_cnt != '0);
    assign instruction = instr_valid ? r_buf_instr[r_head] : 32'h0;
    assign instr_pc    = instr_valid ? r_buf_pc[r_head]    : 32'h0;

    assign w_out_next = r_out + CW'(w_hs) - CW'(w_rsp);

    // On redirect every request still in flight becomes stale.
    always_comb begin
        w_disc_next = r_disc;
        if (w_redirect) begin
            w_disc_next = r_out - CW'(w_rsp);
        end else if (w_rsp && (r_disc != '0)) begin
            w_disc_next = r_disc - CW'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: w_state_next = S_FETCH;
            S_FETCH, S_DRAIN: begin
                if (w_redirect || (r_state == S_DRAIN)) begin
                    w_state_next = (w_disc_next != '0) ? S_DRAIN : S_FETCH;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_out      <= '0;
            r_disc     <= '0;
            r_cnt      <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_state <= w_state_next;
            r_out   <= w_out_next;
            r_disc  <= w_disc_next;
            if (w_redirect) begin
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_cnt      <= '0;
                r_head     <= '0;
                r_tail     <= '0;
            end else begin
                if (w_hs) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                    r_tail   <= ptr_inc(r_tail);
                end
                if (w_pop) begin
                    r_head <= ptr_inc(r_head);
                end
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_tail]    <= r_rsp_pc;
            r_buf_instr[r_tail] <= imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a latency-configurable memory model
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instruction, instr_pc;

    logic        imem2_req_valid, imem2_req_ready;
    logic [31:0] imem2_addr;
    logic        imem2_rsp_valid;
    logic [31:0] imem2_rsp_data;
    logic        redirect2_valid;
    logic [31:0] redirect2_pc;
    logic        instr2_valid, instr2_ready;
    logic [31:0] instruction2, instr2_pc;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .instr_pc(instr_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem2_req_valid), .imem_req_ready(imem2_req_ready), .imem_addr(imem2_addr),
        .imem_rsp_valid(imem2_rsp_valid), .imem_rsp_data(imem2_rsp_data),
        .redirect_valid(redirect2_valid), .redirect_pc(redirect2_pc),
        .instr_valid(instr2_valid), .instr_ready(instr2_ready),
        .instruction(instruction2), .instr_pc(instr2_pc)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          ready_mode = 1'b0;
    int          req_count = 0;
    bit          hs2 = 1'b0;
    pend_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] addr2_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: responses return in order, lat cycles after acceptance.
    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            imem_req_ready = ready_mode ? ((cyc % 3) != 0) : 1'b1;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = pend[0].data;
                void'(pend.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'h0;
            end
            #4;
            if (imem_req_valid && imem_req_ready) begin
                check("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
                pend.push_back('{cyc + lat, mem_word(imem_addr)});
                req_count++;
            end
        end
    end

    initial begin
        imem2_req_ready = 1'b1;
        imem2_rsp_valid = 1'b0;
        imem2_rsp_data  = 32'h0;
        redirect2_valid = 1'b0;
        redirect2_pc    = 32'h0;
        instr2_ready    = 1'b1;
        forever begin
            @(negedge clk);
            imem2_rsp_valid = hs2;
            #4;
            hs2 = imem2_req_valid;
            if (hs2 && addr2_q.size() < 3) addr2_q.push_back(imem2_addr);
        end
    end

    // Monitor: every consumed instruction is compared against the scoreboard head.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (!reset && instr_valid && instr_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got pc %h expected none", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", instr_pc, e);
                    check("instruction", instruction, mem_word(e));
                end
            end
        end
    end

    task automatic do_redirect(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        req_count      = 0;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic wait_req(input int n, input string name);
        for (int k = 0; k < 50 && req_count < n; k++) @(negedge clk);
        check(name, req_count, n);
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i * 4));
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 400 && exp_q.size() > 0; k++) @(negedge clk);
        check(name, exp_q.size(), 0);
        instr_ready = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        @(negedge clk);
        #1;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instruction", instruction, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_addr_dut2", imem2_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        reset = 1'b0;
        #4;
        check("idle_no_req", imem_req_valid, 0);
        @(negedge clk);
        #4;
        check("first_req_valid", imem_req_valid, 1);
        check("first_addr", imem_addr, 32'h0);

        // Sequential fetch with a stalling memory ready.
        @(negedge clk);
        ready_mode = 1'b1;
        push_seq(32'h0, 16);
        instr_ready = 1'b1;
        wait_drain("seq_drain");
        ready_mode = 1'b0;

        // Decode stalled: only DEPTH requests may be issued.
        do_redirect(32'h200);
        repeat (11) @(negedge clk);
        #4;
        check("stall_req_count", req_count, 2);
        check("stall_req_valid", imem_req_valid, 0);
        @(negedge clk);
        push_seq(32'h200, 8);
        instr_ready = 1'b1;
        wait_drain("stall_drain");

        // Redirect with two slow requests in flight.
        lat = 3;
        do_redirect(32'h40);
        wait_req(2, "slow_reqs");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        #4;
        check("drain_req0", imem_req_valid, 0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #4;
        check("drain_req1", imem_req_valid, 0);
        @(negedge clk);
        #4;
        check("drain_req2", imem_req_valid, 0);
        @(negedge clk);
        #4;
        check("drain_exit_req", imem_req_valid, 1);
        check("drain_exit_addr", imem_addr, 32'h100);
        @(negedge clk);
        push_seq(32'h100, 4);
        instr_ready = 1'b1;
        wait_drain("drain_drain");

        // Redirect colliding with a response and a pop while one entry is buffered.
        lat = 1;
        do_redirect(32'h400);
        wait_req(2, "coll_reqs");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h503;
        instr_ready    = 1'b1;
        #4;
        check("coll_pre_valid", instr_valid, 1);
        @(negedge clk);
        redirect_valid = 1'b0;
        #4;
        check("coll_flushed", instr_valid, 0);
        check("coll_req_valid", imem_req_valid, 1);
        check("coll_addr", imem_addr, 32'h500);
        push_seq(32'h500, 8);
        ready_mode = 1'b1;
        wait_drain("coll_drain");
        ready_mode = 1'b0;

        // Reset with requests in flight; late responses must be ignored.
        lat = 3;
        do_redirect(32'h600);
        wait_req(2, "rst_reqs");
        reset = 1'b1;
        #1;
        check("async_req_valid", imem_req_valid, 0);
        check("async_instr_valid", instr_valid, 0);
        check("async_addr", imem_addr, 32'h0);
        check("async_instruction", instruction, 32'h0);
        check("async_instr_pc", instr_pc, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        lat   = 1;
        push_seq(32'h0, 8);
        instr_ready = 1'b1;
        #4;
        check("post_rst_idle", imem_req_valid, 0);
        wait_drain("post_rst_drain");

        check("wrap_count", addr2_q.size(), 3);
        if (addr2_q.size() >= 3) begin
            check("wrap_addr0", addr2_q[0], 32'hFFFF_FFF8);
            check("wrap_addr1", addr2_q[1], 32'hFFFF_FFFC);
            check("wrap_addr2", addr2_q[2], 32'h0000_0000);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
